// File: rtl/operand_issue.sv
// Operand issue stage: queues operand pairs in a small FIFO and issues them to the adder as one-cycle start pulses.
// Latency: a pair pushed at edge N is issued (start/a/b registered) at edge N+1 at the earliest; no bypass.
// Backpressure: in_ready drops when the FIFO is full (even if a pop coincides); enable low pauses issuing.
module operand_issue #(
  parameter int W     = 10,
  parameter int DEPTH = 4,
  parameter int GAP   = 0,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [W-1:0]  in_a,
  input  logic [W-1:0]  in_b,
  output logic          in_ready,
  input  logic          enable,
  output logic          start,
  output logic [W-1:0]  a,
  output logic [W-1:0]  b,
  output logic          busy,
  output logic [LW-1:0] fifo_level,
  output logic [15:0]   issue_count
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic {IDLE, HOLDOFF} state_e;

  state_e          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [LW-1:0]   level_q, level_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [W-1:0]    mem_a [DEPTH];
  logic [W-1:0]    mem_b [DEPTH];
  logic            start_q;
  logic [W-1:0]    a_q, b_q;
  logic [15:0]     issue_cnt_q;
  logic            push, pop;

  // Full is judged on the registered level only, so a same-cycle pop never frees a slot.
  assign in_ready = (level_q < LW'(DEPTH));
  assign push     = in_valid && in_ready;

  // Issue decision and hold-off countdown; the countdown ignores enable once started.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && (level_q != '0)) begin
          pop = 1'b1;
          if (GAP > 0) begin
            state_d = HOLDOFF;
            cnt_d   = 16'(GAP);
          end
        end
      end
      HOLDOFF: begin
        cnt_d = cnt_q - 16'd1;
        if (cnt_q == 16'd1) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Occupancy bookkeeping: simultaneous push and pop leaves the level unchanged.
  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // FSM state and hold-off counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // FIFO pointers and level; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
    end
  end

  // FIFO storage; contents need no reset because the level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr_q] <= in_a;
      mem_b[wr_ptr_q] <= in_b;
    end
  end

  // Registered issue outputs: operands only change on an issue and are held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      issue_cnt_q <= '0;
    end else begin
      start_q <= pop;
      if (pop) begin
        a_q         <= mem_a[rd_ptr_q];
        b_q         <= mem_b[rd_ptr_q];
        issue_cnt_q <= issue_cnt_q + 16'd1;
      end
    end
  end

  assign start       = start_q;
  assign a           = a_q;
  assign b           = b_q;
  assign fifo_level  = level_q;
  assign issue_count = issue_cnt_q;
  assign busy        = (level_q != '0) || (state_q == HOLDOFF);

endmodule

// File: doc/operand_issue.md
# operand_issue

Upstream feeder for the registered two-operand adder stage. Accepts operand pairs over a valid/ready handshake into a small FIFO and issues them to the adder as single-cycle `start` pulses, with registered `a`/`b` held stable between issues. A programmable hold-off gap spaces consecutive issues, and an `enable` input pauses issuing without losing queued data.

## Interface
- `W`, 10, operand width; matches the adder's `W`.
- `DEPTH`, 4, FIFO entries; power of two, at least 2.
- `GAP`, 0, idle cycles forced between consecutive `start` pulses (0 = back-to-back).

- `clk` in 1: single clock; all logic on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream offers an operand pair.
- `in_a` in W: operand A.
- `in_b` in W: operand B.
- `in_ready` out 1: FIFO can accept; equals `fifo_level < DEPTH` (combinational from registered level).
- `enable` in 1: issuing allowed when high.
- `start` out 1: registered one-cycle issue pulse to the adder.
- `a` out W: registered operand A; updates only on issue.
- `b` out W: registered operand B; updates only on issue.
- `busy` out 1: high when `fifo_level != 0` or state is HOLDOFF.
- `fifo_level` out clog2(DEPTH)+1: current entry count.
- `issue_count` out 16: total issues since reset; wraps 65535→0.

## Operation
- Reset values: `start`=0, `a`=0, `b`=0, `fifo_level`=0, `issue_count`=0, `busy`=0, state IDLE, pointers 0, hold-off counter 0.
- Push: `in_valid && in_ready` at an edge writes `{in_a,in_b}` at the write pointer. Pointers wrap modulo DEPTH.
- FSM:
  - IDLE. Issue condition is `enable && fifo_level != 0`. When it holds, pop the head; `start` goes to 1 and `a`/`b` take the head values at the same edge; `issue_count` increments. Next state is HOLDOFF if GAP>0, otherwise IDLE.
  - HOLDOFF. Load counter = GAP on entry. Decrement each cycle regardless of `enable`. Return to IDLE when it reaches 1→0 (exactly GAP cycles with no issue). No pop.
- `start` is high for exactly one cycle per issue. It is 0 in every cycle with no issue.
- `a`/`b` hold their last issued values indefinitely.
- Simultaneous push and pop: `fifo_level` is unchanged and both pointers advance.
- Full: `in_ready`=0, even if a pop occurs in the same cycle (no pass-through on full).
- Empty: no issue. No bypass, so data always spends at least one cycle in the FIFO.
- `enable` deasserted: pending issues wait. A hold-off already in progress still completes.
- `in_valid` with `in_ready`=0: ignored. Upstream must hold its data.
- Reset mid-operation flushes the FIFO, aborts any hold-off and forces all outputs to their reset values immediately (asynchronous).

## Timing
- Push accepted at edge N into an empty FIFO, state IDLE, `enable`=1: `start`=1 with `a`/`b` valid after edge N+1.
- The adder's result appears 2 cycles after `start`. That latency belongs to the adder, not to this block.
- GAP=0: sustained throughput of one issue per cycle while the FIFO is non-empty.
- GAP=g: issues are spaced exactly g+1 cycles apart when data is available and `enable` is high.
- `fifo_level` and `in_ready` reflect the state after the most recent edge.

## Test plan
- Reset, then push (3,5) at edge 1 with `enable`=1 and GAP=0. Required: `start`=1, `a`=3, `b`=5 for one cycle after edge 2, then `start`=0 with `a`/`b` held; `issue_count`=1.
- GAP=0, `enable`=0, push 4 pairs (1,1)…(4,4). Required: `in_ready`=0 and `fifo_level`=4; a 5th pair offered is ignored. Then raise `enable`: 4 consecutive `start` cycles in order, `fifo_level` goes 3,2,1,0.
- GAP=2, 3 pairs queued, `enable`=1. Required: `start` pulses exactly 3 cycles apart (pattern 1,0,0,1,0,0,1); `busy` drops after the final hold-off.
- FIFO at level 2 with a push and an issue in the same cycle. Required: level stays 2 and data order is preserved; run 10 pairs to exercise pointer wrap with no loss or duplication.
- Assert `rst_n`=0 mid-stream with level 3 and GAP=2 hold-off active. Required: immediately `start`=0, `a`=`b`=0, `fifo_level`=0, `issue_count`=0. After release, no stale data is issued.
- Issue 65536 pairs. Required: `issue_count` wraps to 0.
